// File: rtl/axil2iob.sv
// AXI4-Lite slave to single-outstanding native IOB master bridge.
// Ports: clk/rst, s_axil_* AXI4-Lite slave (AW/W/B/AR/R), native valid/addr/wdata/wstrb/rdata/ready.
module axil2iob #(
    parameter int AXIL_ADDR_W = 32,
    parameter int AXIL_DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic [AXIL_ADDR_W-1:0]   s_axil_awaddr,
    input  logic [2:0]               s_axil_awprot,
    input  logic                     s_axil_awvalid,
    output logic                     s_axil_awready,

    input  logic [AXIL_DATA_W-1:0]   s_axil_wdata,
    input  logic [AXIL_DATA_W/8-1:0] s_axil_wstrb,
    input  logic                     s_axil_wvalid,
    output logic                     s_axil_wready,

    output logic [1:0]               s_axil_bresp,
    output logic                     s_axil_bvalid,
    input  logic                     s_axil_bready,

    input  logic [AXIL_ADDR_W-1:0]   s_axil_araddr,
    input  logic [2:0]               s_axil_arprot,
    input  logic                     s_axil_arvalid,
    output logic                     s_axil_arready,

    output logic [AXIL_DATA_W-1:0]   s_axil_rdata,
    output logic [1:0]               s_axil_rresp,
    output logic                     s_axil_rvalid,
    input  logic                     s_axil_rready,

    output logic                     valid,
    output logic [AXIL_ADDR_W-1:0]   addr,
    output logic [AXIL_DATA_W-1:0]   wdata,
    output logic [AXIL_DATA_W/8-1:0] wstrb,
    input  logic [AXIL_DATA_W-1:0]   rdata,
    input  logic                     ready
);

    localparam int STRB_W = AXIL_DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        B_RESP,
        READ,
        R_RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic                   aw_cap;
    logic                   w_cap;
    logic [AXIL_ADDR_W-1:0] awaddr_q;
    logic [AXIL_ADDR_W-1:0] araddr_q;
    logic [AXIL_DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0]      wstrb_q;
    logic [AXIL_DATA_W-1:0] rdata_q;

    logic              aw_hs;
    logic              w_hs;
    logic              ar_hs;
    logic              aw_have;
    logic              w_have;
    logic [STRB_W-1:0] strb_eff;

    logic unused_prot;
    assign unused_prot = ^{s_axil_awprot, s_axil_arprot};

    // Ready outputs are held low while rst is asserted so nothing is accepted
    // in the reset cycle; AR waits for any pending or arriving write.
    always_comb begin
        s_axil_awready = 1'b0;
        s_axil_wready  = 1'b0;
        s_axil_arready = 1'b0;
        if (state == IDLE && !rst) begin
            s_axil_awready = !aw_cap;
            s_axil_wready  = !w_cap;
            s_axil_arready = !aw_cap && !w_cap &&
                             !s_axil_awvalid && !s_axil_wvalid;
        end
    end

    assign aw_hs    = s_axil_awvalid && s_axil_awready;
    assign w_hs     = s_axil_wvalid && s_axil_wready;
    assign ar_hs    = s_axil_arvalid && s_axil_arready;
    assign aw_have  = aw_cap || aw_hs;
    assign w_have   = w_cap || w_hs;
    // The strobe decision must see W data arriving in the same cycle.
    assign strb_eff = w_hs ? s_axil_wstrb : wstrb_q;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (aw_have && w_have) begin
                    state_next = (|strb_eff) ? WRITE : B_RESP;
                end else if (ar_hs) begin
                    state_next = READ;
                end
            end
            WRITE:   if (ready) state_next = B_RESP;
            B_RESP:  if (s_axil_bready) state_next = IDLE;
            READ:    if (ready) state_next = R_RESP;
            R_RESP:  if (s_axil_rready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            aw_cap   <= 1'b0;
            w_cap    <= 1'b0;
            awaddr_q <= '0;
            araddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state <= state_next;
            if (aw_hs) begin
                aw_cap   <= 1'b1;
                awaddr_q <= s_axil_awaddr;
            end
            if (w_hs) begin
                w_cap   <= 1'b1;
                wdata_q <= s_axil_wdata;
                wstrb_q <= s_axil_wstrb;
            end
            if (state == B_RESP && s_axil_bready) begin
                aw_cap <= 1'b0;
                w_cap  <= 1'b0;
            end
            if (ar_hs) begin
                araddr_q <= s_axil_araddr;
            end
            if (state == READ && ready) begin
                rdata_q <= rdata;
            end
        end
    end

    assign valid = (state == WRITE) || (state == READ);
    assign addr  = (state == WRITE) ? awaddr_q : araddr_q;
    assign wdata = wdata_q;
    assign wstrb = (state == WRITE) ? wstrb_q : '0;

    assign s_axil_bvalid = (state == B_RESP);
    assign s_axil_bresp  = 2'b00;
    assign s_axil_rvalid = (state == R_RESP);
    assign s_axil_rresp  = 2'b00;
    assign s_axil_rdata  = rdata_q;

endmodule
